op_replay_buffer: RTL and testbench
===================================

Name: op_replay_buffer

Overview:
- Upstream feeder for the op downsampler: holds one active group of NUM_OPS ops and presents every still-pending slot as base-valid.
- Takes the downsampler's per-slot stall vector back. Non-stalled pending slots are retired; stalled slots are re-presented next cycle.
- The next group is loaded only once every slot of the active group has retired.
- Incoming groups wait in a DEPTH-entry group queue, so the front end can run ahead.

Parameters:
- NUM_OPS, 4, ops per group; matches the downsampler input width.
- OP_SIZE, 64, bits per op.
- DEPTH, 2, queued groups behind the active group (>=1).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- IN_flush  input  1  discard active group and whole queue
- IN_valid  input  1  group offered on IN_ops/IN_opMask
- IN_ops  input  OP_SIZE x NUM_OPS  incoming group
- IN_opMask  input  NUM_OPS  valid slots of incoming group
- OUT_ready  output  1  queue can accept a group this cycle
- IN_opStall  input  NUM_OPS  per-slot stall from downsampler, same cycle
- OUT_ops  output  OP_SIZE x NUM_OPS  active group ops (registered)
- OUT_opBaseValid  output  NUM_OPS  pending mask of active group (registered)
- OUT_empty  output  1  active group and queue both empty
- OUT_count  output  $clog2(DEPTH+1)  groups in queue

Behaviour:
- Interface: single clock clk; rst asynchronous, active-high.
- Reset:
  - pending=0, queue count=0, head/tail pointers=0, OUT_ops=0.
  - Resulting outputs: OUT_opBaseValid=0, OUT_ready=1, OUT_empty=1, OUT_count=0.
- Retire rule: next_pending = pending & IN_opStall. Stall bits on non-pending slots are ignored.
- activeFree = (next_pending==0).
- OUT_ready = (count<DEPTH). It depends on registers only; there is no combinational path from IN_opStall or IN_valid.
- Accept: a group is accepted when IN_valid && OUT_ready && !IN_flush. An accepted group with IN_opMask==0 is dropped and does not occupy a queue entry.
- Load priority when activeFree:
  - Queue head if count>0: pop it.
  - Else the accepted input group, bypassing the queue.
  - Else active stays empty.
- If activeFree is false, an accepted group is pushed at the tail.
- Simultaneous push and pop in one cycle: count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH.
- Latency: a group accepted in cycle N with an empty buffer appears on OUT_opBaseValid in cycle N+1. Each queued group adds one extra cycle after the active group drains.
- Ordering: groups leave in acceptance order. Within a group, slot positions never move.
- Flush:
  - Next cycle: pending=0, count=0, pointers reset.
  - Flush overrides accept, retire and load in that cycle.
  - OUT_ops contents after flush are don't-care and are not cleared.
- OUT_empty = (pending==0 && count==0), from registers.
- OUT_ops of slots where OUT_opBaseValid=0 carry stale data; the consumer must ignore them.
- Reset asserted mid-operation: the whole state returns to reset values immediately, with no partial retire.

Optional Feature:
- Macro: OP_REPLAY_STARVE_EN.
- When defined:
  - Adds parameter STARVE_LIMIT (default 15) and output OUT_starved (1 bit).
  - Adds a saturating counter of consecutive cycles in which pending!=0 and no pending slot retired.
  - The counter resets to 0 on any retire, load, flush or rst.
  - OUT_starved = (counter>=STARVE_LIMIT), registered, reset value 0.
- When undefined: neither the counter nor the port exists, and all other behaviour is identical.

Test Plan:
- Reset then IN_valid=1, mask=4'b1011, IN_opStall=0 -> cycle+1 OUT_opBaseValid=1011; cycle+2 OUT_opBaseValid=0000, OUT_empty=1.
- Active mask=1111, IN_opStall=1100 then 1000 then 0000 -> OUT_opBaseValid goes 1111, 1100, 1000, 0000; slot contents are unchanged throughout.
- DEPTH=2: offer 4 groups back-to-back while IN_opStall=1111 -> OUT_ready=0 after 3 accepts (1 active + 2 queued), OUT_count=2. Release the stall -> groups emerge in order, one per cycle.
- Accept with mask=0000 -> no queue entry, OUT_count unchanged, OUT_empty stays 1.
- Queue count=2, active pending=0101, then IN_flush=1 together with IN_valid=1 -> next cycle OUT_opBaseValid=0, OUT_count=0, input group discarded.
- With OP_REPLAY_STARVE_EN, STARVE_LIMIT=3: hold IN_opStall=1111 on an active group -> OUT_starved=1 by cycle 4 (counter reaches 3 in cycle 3, registered flag rises the next cycle). Release the stall -> OUT_starved=0 the cycle after the retire.

Source files
------------

// File: rtl/op_replay_buffer_if.sv
// op_replay_buffer_if: group input, retire feedback and status signals of the
// op replay buffer. OUT_starved exists only when OP_REPLAY_STARVE_EN is defined.
interface op_replay_buffer_if #(
   parameter int unsigned NUM_OPS = 4,
   parameter int unsigned OP_SIZE = 64,
   parameter int unsigned DEPTH   = 2
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);

   logic                              IN_flush;
   logic                              IN_valid;
   logic [NUM_OPS-1:0][OP_SIZE-1:0]   IN_ops;
   logic [NUM_OPS-1:0]                IN_opMask;
   logic                              OUT_ready;
   logic [NUM_OPS-1:0]                IN_opStall;
   logic [NUM_OPS-1:0][OP_SIZE-1:0]   OUT_ops;
   logic [NUM_OPS-1:0]                OUT_opBaseValid;
   logic                              OUT_empty;
   logic [CNT_W-1:0]                  OUT_count;
`ifdef OP_REPLAY_STARVE_EN
   logic                              OUT_starved;

   modport master (
      output IN_flush, IN_valid, IN_ops, IN_opMask, IN_opStall,
      input  OUT_ready, OUT_ops, OUT_opBaseValid, OUT_empty, OUT_count, OUT_starved
   );

   modport slave (
      input  IN_flush, IN_valid, IN_ops, IN_opMask, IN_opStall,
      output OUT_ready, OUT_ops, OUT_opBaseValid, OUT_empty, OUT_count, OUT_starved
   );
`else
   modport master (
      output IN_flush, IN_valid, IN_ops, IN_opMask, IN_opStall,
      input  OUT_ready, OUT_ops, OUT_opBaseValid, OUT_empty, OUT_count
   );

   modport slave (
      input  IN_flush, IN_valid, IN_ops, IN_opMask, IN_opStall,
      output OUT_ready, OUT_ops, OUT_opBaseValid, OUT_empty, OUT_count
   );
`endif
endinterface

// File: rtl/op_replay_buffer.sv
// op_replay_buffer: holds one active group of NUM_OPS ops, re-presents stalled
// slots until they retire, and buffers up to DEPTH further groups behind it.
// Optional feature macro: OP_REPLAY_STARVE_EN (adds STARVE_LIMIT and OUT_starved).
module op_replay_buffer #(
   parameter int unsigned NUM_OPS = 4,
   parameter int unsigned OP_SIZE = 64,
   parameter int unsigned DEPTH   = 2
`ifdef OP_REPLAY_STARVE_EN
   ,
   parameter int unsigned STARVE_LIMIT = 15
`endif
) (
   input logic              clk,
   input logic              rst,
   op_replay_buffer_if.slave bus
);
   localparam int unsigned CNT_W = $clog2(DEPTH + 1);
   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   typedef logic [NUM_OPS-1:0][OP_SIZE-1:0] group_t;

   logic [NUM_OPS-1:0] pending_q;
   logic [NUM_OPS-1:0] next_pending;
   group_t             ops_q;
   group_t             q_ops  [DEPTH];
   logic [NUM_OPS-1:0] q_mask [DEPTH];
   logic [PTR_W-1:0]   head_q;
   logic [PTR_W-1:0]   tail_q;
   logic [CNT_W-1:0]   count_q;

   logic ready;
   logic active_free;
   logic accept_live;
   logic pop;
   logic bypass;
   logic push;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
   endfunction

   // Ready comes from the queue count register only.
   assign ready = (count_q < CNT_W'(DEPTH));

   // Retire/accept decode. An accepted group either loads straight into the
   // active slot (nothing queued and active drains this cycle) or goes to the
   // tail; pushing while popping the head keeps acceptance order intact.
   always_comb begin
      next_pending = pending_q & bus.IN_opStall;
      active_free  = (next_pending == '0);
      accept_live  = bus.IN_valid && ready && !bus.IN_flush && (bus.IN_opMask != '0);
      pop          = active_free && (count_q != '0);
      bypass       = active_free && (count_q == '0) && accept_live;
      push         = accept_live && !bypass;
   end

   // Active group, pointers and queue occupancy.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pending_q <= '0;
         ops_q     <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else if (bus.IN_flush) begin
         pending_q <= '0;
         head_q    <= '0;
         tail_q    <= '0;
         count_q   <= '0;
      end else begin
         if (pop) begin
            pending_q <= q_mask[head_q];
            ops_q     <= q_ops[head_q];
            head_q    <= ptr_inc(head_q);
         end else if (bypass) begin
            pending_q <= bus.IN_opMask;
            ops_q     <= bus.IN_ops;
         end else begin
            pending_q <= next_pending;
         end
         if (push) begin
            tail_q <= ptr_inc(tail_q);
         end
         if (push && !pop) begin
            count_q <= count_q + 1'b1;
         end else if (pop && !push) begin
            count_q <= count_q - 1'b1;
         end
      end
   end

   // Queue storage; contents need no reset since count gates every read.
   always_ff @(posedge clk) begin
      if (push) begin
         q_ops[tail_q]  <= bus.IN_ops;
         q_mask[tail_q] <= bus.IN_opMask;
      end
   end

   assign bus.OUT_ready       = ready;
   assign bus.OUT_ops         = ops_q;
   assign bus.OUT_opBaseValid = pending_q;
   assign bus.OUT_empty       = (pending_q == '0) && (count_q == '0);
   assign bus.OUT_count       = count_q;

`ifdef OP_REPLAY_STARVE_EN
   localparam int unsigned STV_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

   logic [STV_W-1:0] starve_q;
   logic [STV_W-1:0] starve_d;
   logic             starved_q;

   // Count consecutive cycles with pending work where nothing retires; any
   // retire implies active_free or a shrinking mask, so it clears the count.
   always_comb begin
      starve_d = '0;
      if (!bus.IN_flush && (pending_q != '0) && (next_pending == pending_q)) begin
         starve_d = (starve_q >= STV_W'(STARVE_LIMIT)) ? starve_q : starve_q + 1'b1;
      end
   end

   // Flag is registered from the updated count so it rises the cycle after
   // the limit is reached and drops the cycle after a retire.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         starve_q  <= '0;
         starved_q <= 1'b0;
      end else begin
         starve_q  <= starve_d;
         starved_q <= (starve_d >= STV_W'(STARVE_LIMIT));
      end
   end

   assign bus.OUT_starved = starved_q;
`endif
endmodule

// File: tb/tb_op_replay_buffer.sv
// tb_op_replay_buffer: directed and randomized stimulus checked against a
// queue-based group model of the replay buffer.
module tb_op_replay_buffer;
   localparam int unsigned NUM_OPS = 4;
   localparam int unsigned OP_SIZE = 64;
   localparam int unsigned DEPTH   = 2;
   localparam int unsigned W       = NUM_OPS * OP_SIZE;
`ifdef OP_REPLAY_STARVE_EN
   localparam int unsigned STARVE_LIMIT = 3;
`endif

   logic clk = 1'b0;
   logic rst;

   op_replay_buffer_if #(.NUM_OPS(NUM_OPS), .OP_SIZE(OP_SIZE), .DEPTH(DEPTH)) bus ();

   op_replay_buffer #(
      .NUM_OPS(NUM_OPS),
      .OP_SIZE(OP_SIZE),
      .DEPTH(DEPTH)
`ifdef OP_REPLAY_STARVE_EN
      ,
      .STARVE_LIMIT(STARVE_LIMIT)
`endif
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Reference model: active group plus a FIFO of waiting groups.
   typedef struct {
      logic [NUM_OPS-1:0] mask;
      logic [W-1:0]       ops;
   } grp_t;

   grp_t               mq[$];
   logic [NUM_OPS-1:0] m_pend;
   logic [W-1:0]       m_ops;
   int                 m_stv;
   bit                 m_starved;

   function automatic logic [W-1:0] slot_bits(input logic [NUM_OPS-1:0] m);
      logic [W-1:0] r;
      r = '0;
      for (int i = 0; i < NUM_OPS; i++) if (m[i]) r[i*OP_SIZE +: OP_SIZE] = '1;
      return r;
   endfunction

   function automatic logic [W-1:0] rand_ops();
      logic [W-1:0] r;
      for (int i = 0; i < NUM_OPS; i++) r[i*OP_SIZE +: OP_SIZE] = {$urandom, $urandom};
      return r;
   endfunction

   task automatic model_reset();
      mq.delete();
      m_pend    = '0;
      m_ops     = '0;
      m_stv     = 0;
      m_starved = 0;
   endtask

   task automatic check_all();
      check("base_valid", W'(bus.OUT_opBaseValid), W'(m_pend));
      check("ready", W'(bus.OUT_ready), W'(mq.size() < DEPTH));
      check("empty", W'(bus.OUT_empty), W'((m_pend == '0) && (mq.size() == 0)));
      check("count", W'(bus.OUT_count), W'(mq.size()));
      check("ops", bus.OUT_ops & slot_bits(m_pend), m_ops & slot_bits(m_pend));
`ifdef OP_REPLAY_STARVE_EN
      check("starved", W'(bus.OUT_starved), W'(m_starved));
`endif
   endtask

   // Drive one cycle of inputs, advance the model, then check after the edge.
   task automatic step(input logic v, input logic [NUM_OPS-1:0] mask, input logic [W-1:0] ops,
                       input logic [NUM_OPS-1:0] stall, input logic fl);
      logic [NUM_OPS-1:0] np;
      bit                 acc;
      grp_t               g;
      bus.IN_valid   = v;
      bus.IN_opMask  = mask;
      bus.IN_ops     = ops;
      bus.IN_opStall = stall;
      bus.IN_flush   = fl;
      acc    = v && (mq.size() < DEPTH) && !fl && (mask != '0);
      g.mask = mask;
      g.ops  = ops;
      np     = m_pend & stall;
`ifdef OP_REPLAY_STARVE_EN
      if (!fl && (m_pend != '0) && (np == m_pend)) m_stv = (m_stv < STARVE_LIMIT) ? m_stv + 1 : m_stv;
      else m_stv = 0;
      m_starved = (m_stv >= STARVE_LIMIT);
`endif
      if (fl) begin
         m_pend = '0;
         mq.delete();
      end else if (np != '0) begin
         m_pend = np;
         if (acc) mq.push_back(g);
      end else begin
         if (acc) mq.push_back(g);
         if (mq.size() > 0) begin
            g      = mq.pop_front();
            m_pend = g.mask;
            m_ops  = g.ops;
         end else begin
            m_pend = '0;
         end
      end
      @(posedge clk);
      #1;
      check_all();
   endtask

   task automatic idle(input logic [NUM_OPS-1:0] stall);
      step(1'b0, '0, '0, stall, 1'b0);
   endtask

   initial begin
      rst            = 1'b1;
      bus.IN_valid   = 1'b0;
      bus.IN_flush   = 1'b0;
      bus.IN_opMask  = '0;
      bus.IN_ops     = '0;
      bus.IN_opStall = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_all();
      check("rst_ready", W'(bus.OUT_ready), W'(1'b1));
      check("rst_empty", W'(bus.OUT_empty), W'(1'b1));
      rst = 1'b0;

      // single group, no stall: visible one cycle, then gone
      step(1'b1, 4'b1011, rand_ops(), 4'b0000, 1'b0);
      check("t1_bv", W'(bus.OUT_opBaseValid), W'(4'b1011));
      idle(4'b0000);
      check("t1_drained", W'(bus.OUT_opBaseValid), W'(4'b0000));
      check("t1_empty", W'(bus.OUT_empty), W'(1'b1));

      // partial retire keeps slot positions
      step(1'b1, 4'b1111, rand_ops(), 4'b0000, 1'b0);
      idle(4'b1100);
      check("t2_bv1100", W'(bus.OUT_opBaseValid), W'(4'b1100));
      idle(4'b1000);
      check("t2_bv1000", W'(bus.OUT_opBaseValid), W'(4'b1000));
      idle(4'b0000);
      check("t2_bv0000", W'(bus.OUT_opBaseValid), W'(4'b0000));

      // fill to capacity under full stall, then drain in order
      for (int i = 0; i < 4; i++) step(1'b1, 4'b1111, rand_ops(), 4'b1111, 1'b0);
      check("t3_ready", W'(bus.OUT_ready), W'(1'b0));
      check("t3_count", W'(bus.OUT_count), W'(2));
      for (int i = 0; i < 4; i++) idle(4'b0000);
      check("t3_empty", W'(bus.OUT_empty), W'(1'b1));

      // zero-mask group is dropped
      step(1'b1, 4'b0000, rand_ops(), 4'b0000, 1'b0);
      check("t4_count", W'(bus.OUT_count), W'(0));
      check("t4_empty", W'(bus.OUT_empty), W'(1'b1));

      // flush with a full queue and a concurrent offer
      step(1'b1, 4'b0101, rand_ops(), 4'b1111, 1'b0);
      step(1'b1, 4'b1111, rand_ops(), 4'b1111, 1'b0);
      step(1'b1, 4'b0110, rand_ops(), 4'b1111, 1'b0);
      check("t5_pre_count", W'(bus.OUT_count), W'(2));
      check("t5_pre_bv", W'(bus.OUT_opBaseValid), W'(4'b0101));
      step(1'b1, 4'b1111, rand_ops(), 4'b0000, 1'b1);
      check("t5_bv", W'(bus.OUT_opBaseValid), W'(4'b0000));
      check("t5_count", W'(bus.OUT_count), W'(0));
      idle(4'b0000);
      check("t5_empty", W'(bus.OUT_empty), W'(1'b1));

`ifdef OP_REPLAY_STARVE_EN
      // starvation flag rises after STARVE_LIMIT stalled cycles
      step(1'b1, 4'b1111, rand_ops(), 4'b0000, 1'b0);
      for (int i = 0; i < 3; i++) idle(4'b1111);
      check("t6_starved", W'(bus.OUT_starved), W'(1'b1));
      idle(4'b0000);
      check("t6_released", W'(bus.OUT_starved), W'(1'b0));
`endif

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic               v;
         logic [NUM_OPS-1:0] m;
         logic [NUM_OPS-1:0] s;
         logic               f;
         v = ($urandom_range(0, 3) != 0);
         m = ($urandom_range(0, 7) == 0) ? '0 : NUM_OPS'($urandom);
         s = ($urandom_range(0, 3) == 0) ? '0 : (NUM_OPS'($urandom) & NUM_OPS'($urandom));
         f = ($urandom_range(0, 39) == 0);
         step(v, m, rand_ops(), s, f);
      end

      // asynchronous reset in the middle of activity
      step(1'b1, 4'b1111, rand_ops(), 4'b1111, 1'b0);
      step(1'b1, 4'b1010, rand_ops(), 4'b1111, 1'b0);
      bus.IN_valid = 1'b0;
      rst = 1'b1;
      #2;
      model_reset();
      check_all();
      check("async_rst_bv", W'(bus.OUT_opBaseValid), W'(4'b0000));
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_all();
      for (int i = 0; i < 20; i++) step(1'b1, NUM_OPS'($urandom), rand_ops(), NUM_OPS'($urandom), 1'b0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
